gray_bin_converter_pipe: RTL and testbench

//   Parametrised, pipelined, bidirectional Gray<->binary code converter with valid/ready streaming.

---
 rtl/gray_bin_converter_pipe.sv | 137 +++++++++++++
 tb/tb_gray_bin_converter_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_converter_pipe.sv
// Pipelined bidirectional Gray<->binary converter with valid/ready streaming.
// Stage 1 registers the incoming word, its direction and the Gray adjacency
// verdict; stage 2 holds the converted word and drives the outputs directly.
// A saturating counter tallies adjacency errors as they leave the block.
module gray_bin_converter_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 16,
    parameter bit CHECK_ADJ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_count
);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: XOR with the word shifted right by one.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ {1'b0, b[WIDTH-1:1]};
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves a non-zero word).
    function automatic logic multi_bit_set(input logic [WIDTH-1:0] x);
        return (x & (x - {{(WIDTH-1){1'b0}}, 1'b1})) != {WIDTH{1'b0}};
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_data_r;
    logic             s1_mode_r;
    logic             s1_err_r;
    logic [WIDTH-1:0] hist_r;
    logic             hist_valid_r;
    logic [CNT_W-1:0] err_count_r;
    logic             s2_adv_s;
    logic             in_ready_s;
    logic             adj_err_s;
    logic             out_fire_s;

    // Stage advance: a stage may load when empty or when its content moves on this cycle.
    always_comb begin
        s2_adv_s   = !out_valid || out_ready;
        in_ready_s = !s1_valid_r || s2_adv_s;
        out_fire_s = out_valid && out_ready;
    end

    // Adjacency verdict for the incoming word; only mode-0 words with known history are checked.
    always_comb begin
        adj_err_s = 1'b0;
        if (CHECK_ADJ && !in_mode && hist_valid_r) begin
            adj_err_s = multi_bit_set(in_data ^ hist_r);
        end else begin
            adj_err_s = 1'b0;
        end
    end

    // History of the last accepted mode-0 word; a mode-1 word invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r       <= {WIDTH{1'b0}};
            hist_valid_r <= 1'b0;
        end else if (in_valid && in_ready_s) begin
            if (!in_mode) begin
                hist_r       <= in_data;
                hist_valid_r <= 1'b1;
            end else begin
                hist_valid_r <= 1'b0;
            end
        end
    end

    // Stage 1: capture raw word, direction and adjacency verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {WIDTH{1'b0}};
            s1_mode_r  <= 1'b0;
            s1_err_r   <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= in_data;
                s1_mode_r <= in_mode;
                s1_err_r  <= adj_err_s;
            end
        end
    end

    // Stage 2: convert and hold the result stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= {WIDTH{1'b0}};
            out_mode    <= 1'b0;
            out_adj_err <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data    <= s1_mode_r ? bin_to_gray(s1_data_r) : gray_to_bin(s1_data_r);
                out_mode    <= s1_mode_r;
                out_adj_err <= s1_err_r;
            end
        end
    end

    // Saturating error counter; clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {CNT_W{1'b0}};
        end else if (clr_err) begin
            err_count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s && out_adj_err && !(&err_count_r)) begin
            err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_s;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_gray_bin_converter_pipe.sv
// Scoreboard bench for gray_bin_converter_pipe: a 4-bit instance with a 2-bit
// error counter and an 8-bit instance with the default counter.
module tb_gray_bin_converter_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_mode4, out_adj_err4, clr_err4;
    logic [3:0] in_data4, out_data4;
    logic [1:0] err_count4;

    logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_mode8, out_adj_err8, clr_err8;
    logic [7:0]  in_data8, out_data8;
    logic [15:0] err_count8;

    gray_bin_converter_pipe #(.WIDTH(4), .CNT_W(2), .CHECK_ADJ(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_mode(in_mode4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_mode(out_mode4), .out_adj_err(out_adj_err4),
        .clr_err(clr_err4), .err_count(err_count4));

    gray_bin_converter_pipe #(.WIDTH(8), .CNT_W(16), .CHECK_ADJ(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_mode(out_mode8), .out_adj_err(out_adj_err8),
        .clr_err(clr_err8), .err_count(err_count8));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Scoreboard entries: {adj_err, mode, data[7:0]}
    logic [9:0] q4[$];
    logic [9:0] q8[$];
    logic [3:0] hist4;
    bit         hv4;
    logic [7:0] hist8;
    bit         hv8;
    logic [1:0] exp_cnt4;
    bit         stall4;
    logic [3:0] stall_data4;
    logic [9:0] m4_e, m8_e;
    logic       m4_acc;
    logic [3:0] wd4[6] = '{4'h3, 4'hA, 4'h5, 4'hF, 4'h0, 4'h9};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference conversions written independently of the RTL recurrence.
    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [7:0] ref_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic push4(input logic [3:0] d, input logic m);
        logic e;
        e = 1'b0;
        if (!m) begin
            e = hv4 && ($countones(d ^ hist4) > 1);
            hist4 = d;
            hv4 = 1'b1;
        end else begin
            hv4 = 1'b0;
        end
        q4.push_back({e, m, (m ? ref_b2g({4'h0, d}) : ref_g2b({4'h0, d}))});
    endtask

    task automatic push8(input logic [7:0] d, input logic m);
        logic e;
        e = 1'b0;
        if (!m) begin
            e = hv8 && ($countones(d ^ hist8) > 1);
            hist8 = d;
            hv8 = 1'b1;
        end else begin
            hv8 = 1'b0;
        end
        q8.push_back({e, m, (m ? ref_b2g(d) : ref_g2b(d))});
    endtask

    task automatic drive4(input logic [3:0] d, input logic m);
        int n;
        n = 0;
        in_valid4 = 1'b1; in_data4 = d; in_mode4 = m;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) chk("accept_timeout4", 32'd0, 32'd1);
        else push4(d, m);
        @(posedge clk); #1;
    endtask

    task automatic drive8(input logic [7:0] d, input logic m);
        int n;
        n = 0;
        in_valid8 = 1'b1; in_data8 = d; in_mode8 = m;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) chk("accept_timeout8", 32'd0, 32'd1);
        else push8(d, m);
        @(posedge clk); #1;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        in_valid4 = 1'b0;
        while (q4.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain4", q4.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        in_valid8 = 1'b0;
        while (q8.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain8", q8.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_models();
        q4.delete(); q8.delete();
        hv4 = 1'b0; hv8 = 1'b0; exp_cnt4 = 2'd0;
    endtask

    always @(posedge clk) cyc++;

    // 4-bit monitor: scoreboard compare, hold-stability and error-count model.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall4 = 1'b0;
        end else begin
            chk("err_count4", err_count4, exp_cnt4);
            if (out_valid4 && !out_ready4) begin
                if (stall4) chk("stable4", out_data4, stall_data4);
                stall4 = 1'b1;
                stall_data4 = out_data4;
            end else begin
                stall4 = 1'b0;
            end
            m4_acc = 1'b0;
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    chk("unexpected4", 32'd1, 32'd0);
                end else begin
                    m4_e = q4.pop_front();
                    chk("data4", out_data4, m4_e[3:0]);
                    chk("mode4", out_mode4, m4_e[8]);
                    chk("adj4", out_adj_err4, m4_e[9]);
                    m4_acc = m4_e[9];
                end
            end
            if (clr_err4) exp_cnt4 = 2'd0;
            else if (m4_acc && exp_cnt4 != 2'd3) exp_cnt4 = exp_cnt4 + 2'd1;
        end
    end

    // 8-bit monitor: scoreboard compare.
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("unexpected8", 32'd1, 32'd0);
            end else begin
                m8_e = q8.pop_front();
                chk("data8", out_data8, m8_e[7:0]);
                chk("mode8", out_mode8, m8_e[8]);
                chk("adj8", out_adj_err8, m8_e[9]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, n, c0;
        rst_n = 1'b0;
        in_valid4 = 1'b0; in_data4 = 4'h0; in_mode4 = 1'b0; out_ready4 = 1'b1; clr_err4 = 1'b0;
        in_valid8 = 1'b0; in_data8 = 8'h00; in_mode8 = 1'b0; out_ready8 = 1'b1; clr_err8 = 1'b0;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid4, 1'b0);
        chk("rst_out_data", out_data4, 4'h0);
        chk("rst_out_mode", out_mode4, 1'b0);
        chk("rst_adj_err", out_adj_err4, 1'b0);
        chk("rst_err_count", err_count4, 2'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready4, 1'b1);

        // Gray count sequence back-to-back, latency and throughput.
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = i[3:0];
            drive4(b ^ (b >> 1), 1'b0);
            if (i == 0) chk("latency_early", out_valid4, 1'b0);
            if (i == 1) chk("latency_2", out_valid4, 1'b1);
        end
        chk("throughput", cyc - c0, 16);
        drain4();

        // 8-bit binary->Gray sweep, then Gray->binary round trip.
        for (int i = 0; i < 256; i++) drive8(i[7:0], 1'b1);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            drive8(b ^ (b >> 1), 1'b0);
        end
        drain8();
        chk("err_count8", err_count8, 16'd0);

        // Adjacency checks from a fresh history.
        @(posedge clk); #1;
        rst_n = 1'b0; clear_models();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive4(4'b0000, 1'b0);
        drive4(4'b0011, 1'b0);
        drive4(4'b1000, 1'b0);
        drive4(4'b0000, 1'b0);
        drive4(4'b0101, 1'b0);
        drive4(4'b0101, 1'b0);
        drain4();
        chk("adj_count", err_count4, 2'd3);

        // Backpressure: out_ready low five cycles with input pending.
        out_ready4 = 1'b0;
        k = 0;
        in_valid4 = 1'b1; in_mode4 = 1'b1; in_data4 = wd4[0];
        repeat (5) begin
            @(negedge clk);
            if (in_ready4) begin
                push4(in_data4, 1'b1);
                k++;
            end
            @(posedge clk); #1;
            in_data4 = wd4[k];
        end
        chk("stall_accepts", k, 2);
        chk("stall_in_ready", in_ready4, 1'b0);
        chk("stall_out_valid", out_valid4, 1'b1);
        out_ready4 = 1'b1;
        for (int j = k; j < 6; j++) drive4(wd4[j], 1'b1);
        drain4();

        // Reset with both stages full.
        out_ready4 = 1'b0;
        drive4(4'b0000, 1'b0);
        drive4(4'b0001, 1'b0);
        in_valid4 = 1'b0;
        chk("full_before_rst", out_valid4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid4, 1'b0);
        chk("rst_async_count", err_count4, 2'd0);
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_ghost_output", out_valid4, 1'b0);
        drive4(4'b0111, 1'b0);
        drain4();

        // Saturation and clear-over-increment.
        drive4(4'b0011, 1'b0);
        drive4(4'b0000, 1'b0);
        drive4(4'b0011, 1'b0);
        drive4(4'b0000, 1'b0);
        drive4(4'b0011, 1'b0);
        drain4();
        chk("cnt_saturated", err_count4, 2'd3);
        drive4(4'b0000, 1'b0);
        in_valid4 = 1'b0;
        n = 0;
        while (!(out_valid4 && out_adj_err4) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("err5_seen", out_valid4 && out_adj_err4, 1'b1);
        clr_err4 = 1'b1;
        @(posedge clk); #1;
        clr_err4 = 1'b0;
        chk("clr_wins", err_count4, 2'd0);
        drain4();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
